// File: rtl/aer_addr_seq.sv
// AER synapse address sequencer: manual step/load plus req/ack sweep.
// Optional ack watchdog enabled by AER_ADDR_SEQ_TIMEOUT_EN.
module aer_addr_seq #(
  parameter int ADDR_W      = 5,
  parameter int LAST_ADDR   = 31,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_addr,
  input  logic              wrap_mode,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              start,
  input  logic              ack,
  output logic [ADDR_W-1:0] syn_addr,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              wrapped_q, wrapped_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef AER_ADDR_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q;

  // Counts en-qualified REQ cycles without ack; zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (en) begin
      if (state_q == REQ && !ack) wd_q <= wd_q + 1'b1;
      else                        wd_q <= '0;
    end
  end

  assign timeout = (wd_q == WD_LIM);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_d     = req_q;
    wrapped_d = wrapped_q;
    err_d     = err_q;
    if (en) begin
      wrapped_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          req_d = 1'b0;
          if (start) begin
            addr_d  = '0;
            req_d   = 1'b1;
            err_d   = 1'b0;
            state_d = REQ;
          end else if (load) begin
            addr_d = (load_addr > LAST) ? LAST : load_addr;
          end else if (en_addr) begin
            if (addr_q < LAST) begin
              addr_d = addr_q + 1'b1;
            end else if (wrap_mode) begin
              addr_d    = '0;
              wrapped_d = 1'b1;
            end
          end
        end
        REQ: begin
          if (ack) begin
            req_d   = 1'b0;
            state_d = RELEASE;
          end else if (timeout) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        RELEASE: begin
          if (!ack) begin
            if (addr_q >= LAST) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              req_d   = 1'b1;
              state_d = REQ;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      req_q     <= 1'b0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
    end
  end

  assign syn_addr = addr_q;
  assign req      = req_q;
  assign busy     = (state_q == REQ) || (state_q == RELEASE);
  assign done     = (state_q == DONE);
  assign wrapped  = wrapped_q;
  assign err      = err_q;

endmodule

// File: tb/tb_aer_addr_seq.sv
// Directed bench for aer_addr_seq (default and LAST_ADDR=20 instances).
// Timeout checks follow AER_ADDR_SEQ_TIMEOUT_EN.
module tb_aer_addr_seq;

  logic       clk = 1'b0;
  logic       rst, en, en_addr, wrap_mode, load, start, ack;
  logic [4:0] load_addr;
  logic [4:0] syn_addr, syn20;
  logic       req, busy, done, wrapped, err;
  logic       req20, busy20, done20, wrapped20, err20;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aer_addr_seq #(.ADDR_W(5), .LAST_ADDR(31), .TIMEOUT_CYC(64)) u_dut (
    .clk(clk), .rst(rst), .en(en), .en_addr(en_addr),
    .wrap_mode(wrap_mode), .load(load), .load_addr(load_addr),
    .start(start), .ack(ack), .syn_addr(syn_addr), .req(req),
    .busy(busy), .done(done), .wrapped(wrapped), .err(err)
  );

  aer_addr_seq #(.ADDR_W(5), .LAST_ADDR(20), .TIMEOUT_CYC(64)) u_dut20 (
    .clk(clk), .rst(rst), .en(en), .en_addr(en_addr),
    .wrap_mode(wrap_mode), .load(load), .load_addr(load_addr),
    .start(start), .ack(ack), .syn_addr(syn20), .req(req20),
    .busy(busy20), .done(done20), .wrapped(wrapped20), .err(err20)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a sweep already in REQ at address 0; ack follows req by one cycle.
  task automatic run_sweep(input int freeze_at);
    for (int a = 0; a < 32; a++) begin
      chk("sw_req", req, 1);
      chk("sw_addr", syn_addr, a);
      if (a == freeze_at) begin
        en = 1'b0;
        for (int f = 0; f < 3; f++) begin
          tick();
          chk("frz_req", req, 1);
          chk("frz_addr", syn_addr, a);
        end
        en = 1'b1;
      end
      ack = 1'b1;
      tick();
      chk("rel_req", req, 0);
      chk("rel_busy", busy, 1);
      ack = 1'b0;
      tick();
      if (a < 31) begin
        chk("nx_done", done, 0);
      end else begin
        chk("dn_done", done, 1);
        chk("dn_req", req, 0);
        chk("dn_busy", busy, 0);
        chk("dn_addr", syn_addr, 31);
      end
    end
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_addr = 1'b0; wrap_mode = 1'b0;
    load = 1'b0; load_addr = 5'd0; start = 1'b0; ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_addr", syn_addr, 0);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrapped, 0);
    chk("rst_err", err, 0);

    // Manual wrap
    en = 1'b1; en_addr = 1'b1; wrap_mode = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("wrap_addr", syn_addr, i % 32);
      chk("wrap_pulse", wrapped, (i == 32) ? 1 : 0);
    end
    en_addr = 1'b0;
    tick();
    chk("wrap_clr", wrapped, 0);

    // Load and saturate
    load = 1'b1; load_addr = 5'd29;
    tick();
    chk("load29", syn_addr, 29);
    load = 1'b0; wrap_mode = 1'b0; en_addr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_addr", syn_addr, (i == 0) ? 30 : 31);
      chk("sat_wrap", wrapped, 0);
    end
    en_addr = 1'b0;
    load = 1'b1; load_addr = 5'd31;
    tick();
    chk("load_clamp20", syn20, 20);
    chk("load_31", syn_addr, 31);
    load = 1'b0;

    // ack in IDLE is ignored
    ack = 1'b1;
    tick();
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_req", req, 0);
    ack = 1'b0;

    // Full sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("st_busy", busy, 1);
    run_sweep(-1);

    // Priority then frozen sweep
    start = 1'b1; load = 1'b1; load_addr = 5'd5; en_addr = 1'b1;
    tick();
    start = 1'b0; load = 1'b0; en_addr = 1'b0;
    chk("prio_busy", busy, 1);
    run_sweep(9);

    // Reset mid-sweep in RELEASE at 7
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < 7; a++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
    end
    ack = 1'b1;
    tick();
    chk("pre_rst_addr", syn_addr, 7);
    chk("pre_rst_req", req, 0);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; ack = 1'b0;
    tick();
    chk("mrst_addr", syn_addr, 0);
    chk("mrst_req", req, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    rst = 1'b0;
    tick();
    chk("mrst_done2", done, 0);
    chk("mrst_busy2", busy, 0);

    // Stalled ack
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef AER_ADDR_SEQ_TIMEOUT_EN
    for (int i = 0; i < 63; i++) begin
      tick();
      chk("to_wait_req", req, 1);
    end
    tick();
    chk("to_req", req, 0);
    chk("to_err", err, 1);
    chk("to_addr", syn_addr, 0);
    chk("to_busy", busy, 0);
    chk("to_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_clr", err, 0);
    chk("to_restart", req, 1);
`else
    for (int i = 0; i < 70; i++) tick();
    chk("stall_req", req, 1);
    chk("stall_busy", busy, 1);
    chk("stall_err", err, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
